// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the hybrid-cache line controller.
// Holds the FSM encoding, the WAIT_BUSY timeout and the requester priority.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StScan     = 3'd1,
        StIssue    = 3'd2,
        StWaitBusy = 3'd3,
        StWaitDone = 3'd4
    } ctrl_state_e;

    localparam int unsigned WAIT_BUSY_TIMEOUT = 4;
    localparam int unsigned WAIT_CNT_BITS     = 3;

    typedef enum logic [1:0] {
        ReqNone = 2'd0,
        ReqDcWr = 2'd1,
        ReqDcRd = 2'd2,
        ReqIc   = 2'd3
    } req_e;

    // dcache write miss beats dcache read miss beats icache miss
    function automatic req_e pick_req(input logic dwm, input logic drm, input logic im);
        if (dwm) begin
            return ReqDcWr;
        end else if (drm) begin
            return ReqDcRd;
        end else if (im) begin
            return ReqIc;
        end
        return ReqNone;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Routes the single memory port to the granted cache line and steers
// mem_out_valid / mem_busy back to that line only.
module cache_mem_arbiter #(
    parameter int unsigned NLINES      = 4,
    parameter int unsigned LINEIDXBITS = 2,
    parameter int unsigned ADDRBITS    = 32,
    parameter int unsigned DATABITS    = 32
) (
    input  logic                          grant_valid,
    input  logic [LINEIDXBITS-1:0]        grant,
    input  logic [NLINES*ADDRBITS-1:0]    line_mem_addr,
    input  logic [NLINES*DATABITS-1:0]    line_mem_in,
    input  logic [NLINES-1:0]             line_mem_wrreq,
    input  logic [NLINES-1:0]             line_mem_rdreq,
    input  logic                          mem_out_valid,
    input  logic                          mem_busy,
    output logic [NLINES-1:0]             line_mem_out_valid,
    output logic [NLINES-1:0]             line_pause,
    output logic [ADDRBITS-1:0]           mem_addr,
    output logic [DATABITS-1:0]           mem_in,
    output logic                          mem_wrreq,
    output logic                          mem_rdreq
);

    always_comb begin
        mem_addr           = '0;
        mem_in             = '0;
        mem_wrreq          = 1'b0;
        mem_rdreq          = 1'b0;
        line_mem_out_valid = '0;
        line_pause         = '0;
        if (grant_valid) begin
            mem_addr                  = line_mem_addr[int'(grant)*ADDRBITS +: ADDRBITS];
            mem_in                    = line_mem_in[int'(grant)*DATABITS +: DATABITS];
            mem_wrreq                 = line_mem_wrreq[grant];
            mem_rdreq                 = line_mem_rdreq[grant];
            line_mem_out_valid[grant] = mem_out_valid;
            line_pause[grant]         = mem_busy;
        end
    end

endmodule

// File: rtl/cache_line_ctrl.sv
// Miss sequencer for a bank of cache lines: picks the lowest-TTL victim,
// issues fill / flush+fill and owns the memory port until the refill ends.
module cache_line_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NLINES      = 4,
    parameter int unsigned LINEIDXBITS = 2,
    parameter int unsigned ADDRBITS    = 32,
    parameter int unsigned DATABITS    = 32,
    parameter int unsigned LSBBITS     = 7,
    parameter int unsigned TTLBITS     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDRBITS-1:0]           dcache_rdaddr,
    input  logic                          dcache_rdreq,
    input  logic [ADDRBITS-1:0]           dcache_wraddr,
    input  logic                          dcache_wrreq,
    input  logic [ADDRBITS-1:0]           icache_rdaddr,
    input  logic                          icache_rdreq,
    input  logic [NLINES-1:0]             line_dc_rd_hit,
    input  logic [NLINES-1:0]             line_dc_wr_hit,
    input  logic [NLINES-1:0]             line_ic_hit,
    input  logic [NLINES-1:0]             line_dirty,
    input  logic [NLINES-1:0]             line_ready,
    input  logic [NLINES*TTLBITS-1:0]     line_ttl,
    output logic [NLINES-1:0]             line_flush,
    output logic [NLINES-1:0]             line_fill,
    output logic [NLINES-1:0]             line_pause,
    output logic [ADDRBITS-1:0]           new_region,
    input  logic [NLINES*ADDRBITS-1:0]    line_mem_addr,
    input  logic [NLINES*DATABITS-1:0]    line_mem_in,
    input  logic [NLINES-1:0]             line_mem_wrreq,
    input  logic [NLINES-1:0]             line_mem_rdreq,
    output logic [NLINES-1:0]             line_mem_out_valid,
    output logic [ADDRBITS-1:0]           mem_addr,
    output logic [DATABITS-1:0]           mem_in,
    output logic                          mem_wrreq,
    output logic                          mem_rdreq,
    input  logic                          mem_out_valid,
    input  logic                          mem_busy,
    output logic                          ctrl_stall,
    output logic [LINEIDXBITS-1:0]        ctrl_victim
);

    localparam logic [ADDRBITS-1:0] RegionMask = {{(ADDRBITS-LSBBITS){1'b1}}, {LSBBITS{1'b0}}};

    ctrl_state_e              state_q, state_d;
    logic [LINEIDXBITS-1:0]   cnt_q, cnt_d;
    logic [LINEIDXBITS-1:0]   best_q, best_d;
    logic [TTLBITS-1:0]       bestttl_q, bestttl_d;
    logic [ADDRBITS-1:0]      region_q, region_d;
    logic                     stall_q, stall_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [WAIT_CNT_BITS-1:0] wait_q, wait_d;

    logic                     dwm, drm, im;
    req_e                     req;
    logic [ADDRBITS-1:0]      miss_addr;
    logic [TTLBITS-1:0]       scan_ttl;
    logic [NLINES-1:0]        fill_onehot;

    always_comb begin
        dwm = dcache_wrreq & ~|line_dc_wr_hit;
        drm = dcache_rdreq & ~|line_dc_rd_hit;
        im  = icache_rdreq & ~|line_ic_hit;
        req = pick_req(dwm, drm, im);
        unique case (req)
            ReqDcWr: miss_addr = dcache_wraddr;
            ReqDcRd: miss_addr = dcache_rdaddr;
            ReqIc:   miss_addr = icache_rdaddr;
            default: miss_addr = '0;
        endcase
    end

    assign scan_ttl = line_ttl[int'(cnt_q)*TTLBITS +: TTLBITS];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        best_d        = best_q;
        bestttl_d     = bestttl_q;
        region_d      = region_q;
        stall_d       = stall_q;
        grant_valid_d = grant_valid_q;
        wait_d        = wait_q;
        unique case (state_q)
            StIdle: begin
                if (req != ReqNone) begin
                    region_d  = miss_addr & RegionMask;
                    cnt_d     = '0;
                    best_d    = '0;
                    bestttl_d = '1;
                    stall_d   = 1'b1;
                    state_d   = StScan;
                end
            end
            StScan: begin
                // Strict compare: on a TTL tie the lower index stays the victim
                if (scan_ttl < bestttl_q) begin
                    best_d    = cnt_q;
                    bestttl_d = scan_ttl;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LINEIDXBITS'(NLINES-1)) begin
                    grant_valid_d = 1'b1;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!line_ready[best_q]) begin
                    state_d = StWaitDone;
                end else if (wait_q == WAIT_CNT_BITS'(WAIT_BUSY_TIMEOUT-1)) begin
                    // Line ignored the fill; give up and let the miss re-trigger
                    stall_d       = 1'b0;
                    grant_valid_d = 1'b0;
                    state_d       = StIdle;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (line_ready[best_q]) begin
                    stall_d       = 1'b0;
                    grant_valid_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            best_q        <= '0;
            bestttl_q     <= '1;
            region_q      <= '0;
            stall_q       <= 1'b0;
            grant_valid_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            best_q        <= best_d;
            bestttl_q     <= bestttl_d;
            region_q      <= region_d;
            stall_q       <= stall_d;
            grant_valid_q <= grant_valid_d;
            wait_q        <= wait_d;
        end
    end

    assign fill_onehot = (state_q == StIssue) ? (NLINES'(1) << best_q) : '0;
    assign line_fill   = fill_onehot;
    assign line_flush  = line_dirty[best_q] ? fill_onehot : '0;
    assign new_region  = region_q;
    assign ctrl_stall  = stall_q;
    assign ctrl_victim = best_q;

    cache_mem_arbiter #(
        .NLINES      (NLINES),
        .LINEIDXBITS (LINEIDXBITS),
        .ADDRBITS    (ADDRBITS),
        .DATABITS    (DATABITS)
    ) u_arbiter (
        .grant_valid        (grant_valid_q),
        .grant              (best_q),
        .line_mem_addr      (line_mem_addr),
        .line_mem_in        (line_mem_in),
        .line_mem_wrreq     (line_mem_wrreq),
        .line_mem_rdreq     (line_mem_rdreq),
        .mem_out_valid      (mem_out_valid),
        .mem_busy           (mem_busy),
        .line_mem_out_valid (line_mem_out_valid),
        .line_pause         (line_pause),
        .mem_addr           (mem_addr),
        .mem_in             (mem_in),
        .mem_wrreq          (mem_wrreq),
        .mem_rdreq          (mem_rdreq)
    );

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: table of miss scenarios plus
// hand-written sequences for memory muxing, WAIT_BUSY timeout and reset.
module tb_cache_line_ctrl;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   dcache_rdaddr, dcache_wraddr, icache_rdaddr;
    logic          dcache_rdreq, dcache_wrreq, icache_rdreq;
    logic [3:0]    line_dc_rd_hit, line_dc_wr_hit, line_ic_hit;
    logic [3:0]    line_dirty, line_ready;
    logic [31:0]   line_ttl;
    logic [3:0]    line_flush, line_fill, line_pause;
    logic [31:0]   new_region;
    logic [127:0]  line_mem_addr, line_mem_in;
    logic [3:0]    line_mem_wrreq, line_mem_rdreq, line_mem_out_valid;
    logic [31:0]   mem_addr, mem_in;
    logic          mem_wrreq, mem_rdreq, mem_out_valid, mem_busy;
    logic          ctrl_stall;
    logic [1:0]    ctrl_victim;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_line_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .dcache_rdaddr      (dcache_rdaddr),
        .dcache_rdreq       (dcache_rdreq),
        .dcache_wraddr      (dcache_wraddr),
        .dcache_wrreq       (dcache_wrreq),
        .icache_rdaddr      (icache_rdaddr),
        .icache_rdreq       (icache_rdreq),
        .line_dc_rd_hit     (line_dc_rd_hit),
        .line_dc_wr_hit     (line_dc_wr_hit),
        .line_ic_hit        (line_ic_hit),
        .line_dirty         (line_dirty),
        .line_ready         (line_ready),
        .line_ttl           (line_ttl),
        .line_flush         (line_flush),
        .line_fill          (line_fill),
        .line_pause         (line_pause),
        .new_region         (new_region),
        .line_mem_addr      (line_mem_addr),
        .line_mem_in        (line_mem_in),
        .line_mem_wrreq     (line_mem_wrreq),
        .line_mem_rdreq     (line_mem_rdreq),
        .line_mem_out_valid (line_mem_out_valid),
        .mem_addr           (mem_addr),
        .mem_in             (mem_in),
        .mem_wrreq          (mem_wrreq),
        .mem_rdreq          (mem_rdreq),
        .mem_out_valid      (mem_out_valid),
        .mem_busy           (mem_busy),
        .ctrl_stall         (ctrl_stall),
        .ctrl_victim        (ctrl_victim)
    );

    typedef struct packed {
        logic [31:0] rdaddr;
        logic        rdreq;
        logic [31:0] wraddr;
        logic        wrreq;
        logic [31:0] icaddr;
        logic        icreq;
        logic [3:0]  rd_hit;
        logic [3:0]  wr_hit;
        logic [3:0]  ic_hit;
        logic [31:0] ttl;      // {line3, line2, line1, line0}
        logic [3:0]  dirty;
        logic [3:0]  exp_fill;
        logic [3:0]  exp_flush;
        logic [1:0]  exp_victim;
        logic [31:0] exp_region;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a miss from IDLE and walks it through SCAN/ISSUE into WAIT_DONE.
    task automatic start_miss(input vec_t v);
        dcache_rdaddr  = v.rdaddr;
        dcache_rdreq   = v.rdreq;
        dcache_wraddr  = v.wraddr;
        dcache_wrreq   = v.wrreq;
        icache_rdaddr  = v.icaddr;
        icache_rdreq   = v.icreq;
        line_dc_rd_hit = v.rd_hit;
        line_dc_wr_hit = v.wr_hit;
        line_ic_hit    = v.ic_hit;
        line_ttl       = v.ttl;
        line_dirty     = v.dirty;
        tick();
        chk("stall_rise", ctrl_stall, 1'b1);
        // Withdraw and scramble requests; the latched region must not move
        dcache_rdreq  = 1'b0;
        dcache_wrreq  = 1'b0;
        icache_rdreq  = 1'b0;
        dcache_rdaddr = 32'hFFFF_FFFF;
        dcache_wraddr = 32'hFFFF_FFFF;
        icache_rdaddr = 32'hFFFF_FFFF;
        repeat (3) begin
            tick();
            chk("scan_no_fill", line_fill, 4'b0000);
        end
        tick();
        chk("issue_fill", line_fill, v.exp_fill);
        chk("issue_flush", line_flush, v.exp_flush);
        chk("issue_victim", ctrl_victim, v.exp_victim);
        chk("issue_region", new_region, v.exp_region);
        tick();
        chk("pulse_fill_end", line_fill, 4'b0000);
        chk("pulse_flush_end", line_flush, 4'b0000);
        line_ready = ~v.exp_fill;
        tick();
        chk("wait_done_stall", ctrl_stall, 1'b1);
        chk("wait_done_region", new_region, v.exp_region);
    endtask

    task automatic finish_refill();
        line_ready = 4'b1111;
        tick();
        chk("refill_done_stall", ctrl_stall, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1080, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0,
                    {8'd200, 8'd10, 8'd10, 8'd40}, 4'b0000, 4'b0010, 4'b0000, 2'd1,
                    32'h0000_1080};
        vecs[1] = '{32'h0000_1080, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0,
                    {8'd200, 8'd10, 8'd10, 8'd40}, 4'b0010, 4'b0010, 4'b0010, 2'd1,
                    32'h0000_1080};
        vecs[2] = '{32'h0, 1'b0, 32'h0000_2000, 1'b1, 32'h0000_3000, 1'b1, 4'h0, 4'h0, 4'h0,
                    {8'd3, 8'd3, 8'd9, 8'd5}, 4'b0100, 4'b0100, 4'b0100, 2'd2,
                    32'h0000_2000};
        vecs[3] = '{32'h0000_1234, 1'b1, 32'h0, 1'b0, 32'h0000_5000, 1'b1, 4'b0001, 4'h0, 4'h0,
                    {8'd255, 8'd255, 8'd255, 8'd255}, 4'b1110, 4'b0001, 4'b0000, 2'd0,
                    32'h0000_5000};
        vecs[4] = '{32'h0000_12FF, 1'b1, 32'h0000_9000, 1'b1, 32'h0000_7000, 1'b1, 4'h0,
                    4'b0100, 4'h0, {8'd1, 8'd50, 8'd100, 8'd200}, 4'b1111, 4'b1000, 4'b1000,
                    2'd3, 32'h0000_1280};

        reset_n        = 1'b0;
        dcache_rdaddr  = '0;
        dcache_wraddr  = '0;
        icache_rdaddr  = '0;
        dcache_rdreq   = 1'b0;
        dcache_wrreq   = 1'b0;
        icache_rdreq   = 1'b0;
        line_dc_rd_hit = '0;
        line_dc_wr_hit = '0;
        line_ic_hit    = '0;
        line_dirty     = '0;
        line_ready     = 4'b1111;
        line_ttl       = '0;
        line_mem_addr  = '0;
        line_mem_in    = '0;
        line_mem_wrreq = '0;
        line_mem_rdreq = '0;
        mem_out_valid  = 1'b0;
        mem_busy       = 1'b0;

        #12;
        chk("rst_stall", ctrl_stall, 1'b0);
        chk("rst_fill_flush", {line_fill, line_flush}, 8'h00);
        chk("rst_region", new_region, 32'h0);
        chk("rst_victim", ctrl_victim, 2'd0);
        chk("rst_mem_req", {mem_rdreq, mem_wrreq}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_no_stall", ctrl_stall, 1'b0);

        for (int i = 0; i < 5; i++) begin
            start_miss(vecs[i]);
            finish_refill();
        end

        // Memory port routed to the granted line during WAIT_DONE
        start_miss(vecs[0]);
        line_mem_addr  = {32'h0000_3333, 32'h0000_2222, 32'h0000_2004, 32'h0000_DEAD};
        line_mem_in    = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_0001, 32'hDEAD_0000};
        line_mem_rdreq = 4'b0010;
        line_mem_wrreq = 4'b0001;
        mem_busy       = 1'b1;
        mem_out_valid  = 1'b1;
        #1;
        chk("mux_addr", mem_addr, 32'h0000_2004);
        chk("mux_in", mem_in, 32'hCAFE_0001);
        chk("mux_rdreq", mem_rdreq, 1'b1);
        chk("mux_wrreq", mem_wrreq, 1'b0);
        chk("mux_pause", line_pause, 4'b0010);
        chk("mux_valid", line_mem_out_valid, 4'b0010);
        finish_refill();
        chk("nogrant_rdreq", {mem_rdreq, mem_wrreq}, 2'b00);
        chk("nogrant_valid", line_mem_out_valid, 4'b0000);
        chk("nogrant_pause", line_pause, 4'b0000);
        line_mem_wrreq = '0;
        mem_busy       = 1'b0;
        mem_out_valid  = 1'b0;

        // Victim never drops ready: 4 WAIT_BUSY cycles then back to IDLE and retry
        dcache_rdaddr = 32'h0000_1080;
        dcache_rdreq  = 1'b1;
        line_ttl      = vecs[0].ttl;
        line_dirty    = 4'b0000;
        repeat (9) tick();
        chk("tmo_stall_hold", ctrl_stall, 1'b1);
        chk("tmo_grant_held", mem_rdreq, 1'b1);
        tick();
        chk("tmo_idle_stall", ctrl_stall, 1'b0);
        chk("tmo_grant_free", mem_rdreq, 1'b0);
        tick();
        chk("tmo_retry_stall", ctrl_stall, 1'b1);
        dcache_rdreq = 1'b0;
        repeat (12) tick();
        chk("tmo_settle", ctrl_stall, 1'b0);

        // Asynchronous reset while in WAIT_DONE with line 1 still requesting
        start_miss(vecs[1]);
        mem_busy      = 1'b1;
        mem_out_valid = 1'b1;
        #1;
        chk("pre_rst_rdreq", mem_rdreq, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_stall", ctrl_stall, 1'b0);
        chk("arst_rdreq", mem_rdreq, 1'b0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_pause_valid", {line_pause, line_mem_out_valid}, 8'h00);
        chk("arst_region", new_region, 32'h0);
        chk("arst_victim", ctrl_victim, 2'd0);
        #2;
        reset_n    = 1'b1;
        line_ready = 4'b1111;
        tick();
        chk("post_rst_stall", ctrl_stall, 1'b0);
        chk("post_rst_rdreq", mem_rdreq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
